// File: rtl/rgb_sbit_decode_if.sv
// Serial line and decoded-event strobes between a WS2812-style line and its decoder.
// The decoder takes the slave side; the line driver / event consumer takes the master side.
interface rgb_sbit_decode_if;
    logic in_serial;
    logic out_strobe;
    logic out_sbit_value;
    logic out_stream_reset;
    logic out_stuck_high;

    modport master (
        output in_serial,
        input  out_strobe,
        input  out_sbit_value,
        input  out_stream_reset,
        input  out_stuck_high
    );

    modport slave (
        input  in_serial,
        output out_strobe,
        output out_sbit_value,
        output out_stream_reset,
        output out_stuck_high
    );
endinterface

// File: rtl/rgb_sbit_decode.sv
// Classifies WS2812-style high pulses as 0/1 by width and flags the long-low stream reset,
// emitting one registered strobe per decoded event.
module rgb_sbit_decode #(
    parameter int SAMPLE_TIME_CLKS  = 57,
    parameter int MIN_HIGH_CLKS     = 8,
    parameter int STREAM_RESET_CLKS = 4800,
    parameter int COUNTER_MAX       = 5000,
    parameter int CNT_W             = 13
) (
    input  logic               clk,
    input  logic               rst,
    rgb_sbit_decode_if.slave   bus
);

    localparam logic [CNT_W-1:0] SAMPLE_C = CNT_W'(SAMPLE_TIME_CLKS);
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_HIGH_CLKS);
    localparam logic [CNT_W-1:0] SRST_C   = CNT_W'(STREAM_RESET_CLKS);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(COUNTER_MAX);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    typedef enum logic [2:0] {
        WAIT_LOW,
        IDLE,
        HIGH,
        LOW_PEND,
        HIGH_DONE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             s1_q;
    logic             s2_q;
    logic             strobe_q;
    logic             sbit_q;
    logic             srst_q;
    logic             stuck_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= MAX_C) ? MAX_C : v + ONE_C;
    endfunction

    assign cnt_d = sat_inc(cnt_q);

    // Synchronizer idles high so a reset inside a pulse parks in WAIT_LOW until the line falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            state_q  <= WAIT_LOW;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            sbit_q   <= 1'b0;
            srst_q   <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            s1_q     <= bus.in_serial;
            s2_q     <= s1_q;
            strobe_q <= 1'b0;
            sbit_q   <= 1'b0;
            srst_q   <= 1'b0;
            stuck_q  <= 1'b0;
            case (state_q)
                WAIT_LOW: begin
                    if (!s2_q) begin
                        state_q <= IDLE;
                        cnt_q   <= ONE_C;
                    end
                end
                IDLE: begin
                    // Counter saturates past the threshold, so this fires once per low interval.
                    if (cnt_q == SRST_C) begin
                        strobe_q <= 1'b1;
                        srst_q   <= 1'b1;
                    end
                    if (s2_q) begin
                        state_q <= HIGH;
                        cnt_q   <= ONE_C;
                    end else begin
                        cnt_q   <= cnt_d;
                    end
                end
                HIGH: begin
                    if (cnt_q >= SAMPLE_C) begin
                        strobe_q <= 1'b1;
                        sbit_q   <= 1'b1;
                        if (s2_q) begin
                            state_q <= HIGH_DONE;
                            cnt_q   <= cnt_d;
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= ONE_C;
                        end
                    end else if (!s2_q) begin
                        if (cnt_q < MIN_C) begin
                            state_q <= IDLE;
                            cnt_q   <= ONE_C;
                        end else begin
                            state_q <= LOW_PEND;
                            cnt_q   <= cnt_d;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                LOW_PEND: begin
                    // Waiting out the sample point keeps 0 and 1 strobes at the same latency.
                    if (cnt_q >= SAMPLE_C) begin
                        strobe_q <= 1'b1;
                        if (s2_q) begin
                            state_q <= WAIT_LOW;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= ONE_C;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                HIGH_DONE: begin
                    if (!s2_q) begin
                        state_q <= IDLE;
                        cnt_q   <= ONE_C;
                    end else begin
                        cnt_q   <= cnt_d;
                        stuck_q <= (cnt_d >= MAX_C);
                    end
                end
                default: begin
                    state_q <= WAIT_LOW;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.out_strobe       = strobe_q;
    assign bus.out_sbit_value   = sbit_q;
    assign bus.out_stream_reset = srst_q;
    assign bus.out_stuck_high   = stuck_q;

endmodule
